// File: rtl/uart_tx_frame_engine_if.sv
// rtl/uart_tx_frame_engine_if.sv - handshake/serial signal bundle for uart_tx_frame_engine
// Purpose: groups the start strobe, the memory byte handshake and the serial/status outputs.
// Signals:
//   iSTART     start pulse (master -> engine)
//   iTX_DATA   byte from the TX text memory (master -> engine)
//   oTX_REQ    byte request strobe (engine -> master)
//   oFINISH    end-of-message strobe (engine -> master)
//   oTXD       serial line, idle high (engine -> master)
//   oBUSY      engine not idle (engine -> master)
//   oBYTE_CNT  bytes sent in current/last message (engine -> master)
interface uart_tx_frame_engine_if;
  logic       iSTART;
  logic [7:0] iTX_DATA;
  logic       oTX_REQ;
  logic       oFINISH;
  logic       oTXD;
  logic       oBUSY;
  logic [7:0] oBYTE_CNT;

  modport master (
    output iSTART, iTX_DATA,
    input  oTX_REQ, oFINISH, oTXD, oBUSY, oBYTE_CNT
  );

  modport slave (
    input  iSTART, iTX_DATA,
    output oTX_REQ, oFINISH, oTXD, oBUSY, oBYTE_CNT
  );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - fetches bytes from the TX memory and serializes them onto TXD
// Purpose: requests one byte at a time from the TX text memory and sends each as an 8N1 frame
//   (8E1 when UART_TX_PARITY_EN is defined). A message ends on 0x0A (sent), 0xFF (not sent)
//   or after MAX_BYTES bytes; oFINISH then pulses to rewind the memory.
// Parameters: CLK_HZ, BAUD (DIV = CLK_HZ/BAUD clocks per bit, DIV >= 4), MAX_BYTES (1..255).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    uart_tx_frame_engine_if.slave: iSTART, iTX_DATA in; oTX_REQ, oFINISH, oTXD,
//          oBUSY, oBYTE_CNT out (all outputs registered)
// Configuration macro: UART_TX_PARITY_EN (adds an even-parity bit between data and stop).
module uart_tx_frame_engine #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int MAX_BYTES = 64
) (
  input logic                   clk,
  input logic                   reset,
  uart_tx_frame_engine_if.slave bus
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
  localparam logic [7:0]    MAX_CNT   = 8'(MAX_BYTES);

  typedef enum logic [3:0] {
    stIdle, stReq, stWait, stLoad, stStart, stData, stStop, stDone
`ifdef UART_TX_PARITY_EN
    , stParity
`endif
  } stateT;

  stateT         state;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    txByte;

  wire bitEnd = (baudCnt == LAST_TICK);

  // Outputs are registered and updated on the transition into a state, so each output
  // lines up exactly with the state it belongs to (oTXD=0 starts the cycle after LOAD).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= stIdle;
      baudCnt       <= '0;
      bitIdx        <= '0;
      txByte        <= '0;
      bus.oTXD      <= 1'b1;
      bus.oTX_REQ   <= 1'b0;
      bus.oFINISH   <= 1'b0;
      bus.oBUSY     <= 1'b0;
      bus.oBYTE_CNT <= '0;
    end else begin
      bus.oTX_REQ <= 1'b0;
      bus.oFINISH <= 1'b0;
      case (state)
        stIdle: begin
          if (bus.iSTART) begin
            state         <= stReq;
            bus.oTX_REQ   <= 1'b1;
            bus.oBUSY     <= 1'b1;
            bus.oBYTE_CNT <= '0;
          end
        end
        stReq:  state <= stWait;
        // Memory output is edge-clocked off oTX_REQ; give it a cycle to settle.
        stWait: state <= stLoad;
        stLoad: begin
          if (bus.iTX_DATA == 8'hFF) begin
            state       <= stDone;
            bus.oFINISH <= 1'b1;
          end else begin
            state         <= stStart;
            txByte        <= bus.iTX_DATA;
            bus.oBYTE_CNT <= bus.oBYTE_CNT + 8'd1;
            bus.oTXD      <= 1'b0;
            baudCnt       <= '0;
          end
        end
        stStart: begin
          if (bitEnd) begin
            state    <= stData;
            baudCnt  <= '0;
            bitIdx   <= '0;
            bus.oTXD <= txByte[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        stData: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= stParity;
              bus.oTXD <= ^txByte;
`else
              state    <= stStop;
              bus.oTXD <= 1'b1;
`endif
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              bus.oTXD <= txByte[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        stParity: begin
          if (bitEnd) begin
            state    <= stStop;
            baudCnt  <= '0;
            bus.oTXD <= 1'b1;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
`endif
        stStop: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (txByte == 8'h0A || bus.oBYTE_CNT == MAX_CNT) begin
              state       <= stDone;
              bus.oFINISH <= 1'b1;
            end else begin
              state       <= stReq;
              bus.oTX_REQ <= 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        stDone: begin
          state     <= stIdle;
          bus.oBUSY <= 1'b0;
        end
        default: begin
          state     <= stIdle;
          bus.oBUSY <= 1'b0;
          bus.oTXD  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb/tb_uart_tx_frame_engine.sv - self-checking bench for uart_tx_frame_engine
module tb_uart_tx_frame_engine;
  localparam int DIV  = 10;
  localparam int MAXB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * DIV;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_engine_if ifc ();

  uart_tx_frame_engine #(.CLK_HZ(1000), .BAUD(100), .MAX_BYTES(MAXB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int nCmp = 0;
  int nBad = 0;

  // TX text memory model: presents the next byte while oTX_REQ is high, rewinds on oFINISH.
  logic [7:0] mem [8];
  int memIdx;
  always @(negedge clk) begin
    if (!reset || ifc.oFINISH) memIdx = 0;
    else if (ifc.oTX_REQ) begin
      ifc.iTX_DATA = mem[memIdx % 8];
      memIdx++;
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    nCmp++;
    assert (observed === expected) else begin
      nBad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: derive the sent bytes and the per-cycle waveform from the message rules,
  // then compare every cycle from the start pulse to one cycle past oFINISH.
  task automatic runMsg(input string name, input logic [7:0] m [8], input int pulseAt);
    logic [7:0] sent [$];
    int reqs, fin, n, pulse;
    bit ff;
    int eTxd, eReq, eFin, eBusy;
    int bTxd, bReq, bFin, bBusy, fTxd, fReq, fFin, fBusy;
    logic [7:0] cur;
    reqs = 0; ff = 0;
    for (int i = 0; i < 8; i++) begin
      reqs++;
      if (m[i] == 8'hFF) begin ff = 1; break; end
      sent.push_back(m[i]);
      if (m[i] == 8'h0A || sent.size() == MAXB) break;
    end
    n = sent.size();
    fin = ff ? n * (FL + 3) + 3 : n * (FL + 3);
    pulse = (pulseAt < fin) ? pulseAt : -1;
    for (int i = 0; i < 8; i++) mem[i] = m[i];
    bTxd = 0; bReq = 0; bFin = 0; bBusy = 0;
    fTxd = -1; fReq = -1; fFin = -1; fBusy = -1;
    @(negedge clk);
    ifc.iSTART = 1'b1;
    for (int t = 0; t <= fin + 1; t++) begin
      @(negedge clk);
      ifc.iSTART = (t == pulse);
      eTxd = 1;
      for (int k = 0; k < n; k++) begin
        int s, b;
        s = 3 + k * (FL + 3);
        if (t >= s && t < s + FL) begin
          b = (t - s) / DIV;
          cur = sent[k];
          if (b == 0) eTxd = 0;
          else if (b <= 8) eTxd = int'(cur[b-1]);
          else if (NBITS == 11 && b == 9) eTxd = int'(^cur);
          else eTxd = 1;
        end
      end
      eReq = 0;
      for (int k = 0; k < reqs; k++) if (t == k * (FL + 3)) eReq = 1;
      eFin  = (t == fin) ? 1 : 0;
      eBusy = (t <= fin) ? 1 : 0;
      if (int'(ifc.oTXD) !== eTxd) begin bTxd++; if (fTxd < 0) fTxd = t; end
      if (int'(ifc.oTX_REQ) !== eReq) begin bReq++; if (fReq < 0) fReq = t; end
      if (int'(ifc.oFINISH) !== eFin) begin bFin++; if (fFin < 0) fFin = t; end
      if (int'(ifc.oBUSY) !== eBusy) begin bBusy++; if (fBusy < 0) fBusy = t; end
    end
    ifc.iSTART = 1'b0;
    check($sformatf("%s txd bad_cycles(first t=%0d)", name, fTxd), bTxd, 0);
    check($sformatf("%s tx_req bad_cycles(first t=%0d)", name, fReq), bReq, 0);
    check($sformatf("%s finish bad_cycles(first t=%0d)", name, fFin), bFin, 0);
    check($sformatf("%s busy bad_cycles(first t=%0d)", name, fBusy), bBusy, 0);
    check($sformatf("%s byte_cnt", name), int'(ifc.oBYTE_CNT), n);
    repeat (5) @(negedge clk);
    check($sformatf("%s byte_cnt_hold", name), int'(ifc.oBYTE_CNT), n);
    check($sformatf("%s idle_txd", name), int'(ifc.oTXD), 1);
  endtask

  initial begin
    logic [7:0] msg [8];
    reset = 1'b0;
    ifc.iSTART = 1'b0;
    repeat (3) @(negedge clk);
    check("reset txd", int'(ifc.oTXD), 1);
    check("reset tx_req", int'(ifc.oTX_REQ), 0);
    check("reset finish", int'(ifc.oFINISH), 0);
    check("reset busy", int'(ifc.oBUSY), 0);
    check("reset byte_cnt", int'(ifc.oBYTE_CNT), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    msg = '{8'h63, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    runMsg("msg63_0A", msg, -1);
    msg = '{8'hFF, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    runMsg("ff_first", msg, -1);
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    runMsg("max_bytes", msg, -1);
    msg = '{8'h5A, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    runMsg("restart_in_data", msg, 3 + DIV + 25);
    msg = '{8'h07, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    runMsg("byte07", msg, -1);
    msg = '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    runMsg("byte03_ff", msg, -1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        msg[i] = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h0A : 8'($urandom_range(0, 254));
      end
      runMsg($sformatf("rand%0d", r), msg,
             ($urandom_range(0, 1) == 1) ? 3 + DIV + int'($urandom_range(0, 7 * DIV)) : -1);
    end

    // Asynchronous reset during a data bit of 0x00 must raise TXD before the next edge.
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    @(negedge clk);
    ifc.iSTART = 1'b1;
    @(negedge clk);
    ifc.iSTART = 1'b0;
    repeat (3 + DIV + DIV / 2) @(negedge clk);
    check("mid_data txd_low", int'(ifc.oTXD), 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset txd", int'(ifc.oTXD), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset busy", int'(ifc.oBUSY), 0);
    check("post_reset tx_req", int'(ifc.oTX_REQ), 0);
    check("post_reset byte_cnt", int'(ifc.oBYTE_CNT), 0);
    check("post_reset txd", int'(ifc.oTXD), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
